// File: rtl/btn_debounce_4_if.sv
// Signal bundle between the four-button conditioner and its consumers.
// The slave side is the conditioner. The master side drives the raw pins and reads the conditioned outputs.
interface btn_debounce_4_if;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [1:0] sel_idx;
  logic       sel_valid;
  logic       any_pressed;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, sel_idx, sel_valid, any_pressed
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, sel_idx, sel_valid, any_pressed
  );
endinterface

// File: rtl/btn_debounce_4.sv
// Four-channel button conditioner: 2-FF sync, per-channel debounce FSM, press/release pulses, last-pressed index.
// Optional auto-repeat of press pulses while held: define BTN_AUTOREPEAT_EN.
module btn_debounce_4 #(
  parameter int DEBOUNCE_CNT = 250000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input logic             clk,
  input logic             rst,
  btn_debounce_4_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT);
  // Accept on the cycle the count would reach DEBOUNCE_CNT-1, so the registered outputs land at 2+DEBOUNCE_CNT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_SPAN = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W    = ($clog2(RPT_SPAN) < 1) ? 1 : $clog2(RPT_SPAN);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [RPT_W-1:0] RPT_SAT   = '1;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  logic [3:0] s0_q, s1_q;
  logic [3:0] level_q, press_q, release_q;
  logic [1:0] sel_idx_q, sel_idx_d;
  logic       sel_valid_q, sel_valid_d;
  logic       any_pressed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= bus.btn_in;
      s1_q <= s0_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      deb_state_e       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             lvl_q, lvl_d;
      logic             prs_q, prs_d;
      logic             rel_q, rel_d;
`ifdef BTN_AUTOREPEAT_EN
      logic [RPT_W-1:0] rpt_q, rpt_d;
      logic             armed_q, armed_d;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= RELEASED;
          cnt_q   <= '0;
          lvl_q   <= 1'b0;
          prs_q   <= 1'b0;
          rel_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
          rpt_q   <= '0;
          armed_q <= 1'b0;
`endif
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          lvl_q   <= lvl_d;
          prs_q   <= prs_d;
          rel_q   <= rel_d;
`ifdef BTN_AUTOREPEAT_EN
          rpt_q   <= rpt_d;
          armed_q <= armed_d;
`endif
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        prs_d   = 1'b0;
        rel_d   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_d   = rpt_q;
        armed_d = armed_q;
`endif
        case (state_q)
          RELEASED: begin
            if (s1_q[gi]) begin
              state_d = PRESS_WAIT;
              cnt_d   = '0;
            end
          end
          PRESS_WAIT: begin
            if (!s1_q[gi]) begin
              state_d = RELEASED;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = PRESSED;
              cnt_d   = '0;
              lvl_d   = 1'b1;
              prs_d   = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              rpt_d   = '0;
              armed_d = 1'b0;
`endif
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!s1_q[gi]) begin
              state_d = RELEASE_WAIT;
              cnt_d   = '0;
`ifdef BTN_AUTOREPEAT_EN
              rpt_d   = '0;
              armed_d = 1'b0;
            end else if (!armed_q && rpt_q == RPT_FIRST) begin
              prs_d   = 1'b1;
              rpt_d   = '0;
              armed_d = 1'b1;
            end else if (armed_q && rpt_q == RPT_NEXT) begin
              prs_d   = 1'b1;
              rpt_d   = '0;
            end else if (rpt_q != RPT_SAT) begin
              rpt_d = rpt_q + RPT_W'(1);
`endif
            end
          end
          RELEASE_WAIT: begin
            // A bounce back high returns to PRESSED silently; the level never dropped.
            if (s1_q[gi]) begin
              state_d = PRESSED;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = RELEASED;
              cnt_d   = '0;
              lvl_d   = 1'b0;
              rel_d   = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: state_d = RELEASED;
        endcase
      end

      assign level_q[gi]   = lvl_q;
      assign press_q[gi]   = prs_q;
      assign release_q[gi] = rel_q;
    end
  endgenerate

  // Lowest index wins: later assignments override earlier ones.
  always_comb begin
    sel_idx_d   = sel_idx_q;
    sel_valid_d = sel_valid_q;
    if (press_q[3]) sel_idx_d = 2'd3;
    if (press_q[2]) sel_idx_d = 2'd2;
    if (press_q[1]) sel_idx_d = 2'd1;
    if (press_q[0]) sel_idx_d = 2'd0;
    if (|press_q)   sel_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_idx_q     <= 2'd0;
      sel_valid_q   <= 1'b0;
      any_pressed_q <= 1'b0;
    end else begin
      sel_idx_q     <= sel_idx_d;
      sel_valid_q   <= sel_valid_d;
      any_pressed_q <= |level_q;
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.sel_idx     = sel_idx_q;
  assign bus.sel_valid   = sel_valid_q;
  assign bus.any_pressed = any_pressed_q;

endmodule

// File: tb/tb_btn_debounce_4.sv
// Directed bench for btn_debounce_4 with DEBOUNCE_CNT=8, REPEAT_DELAY=20, REPEAT_RATE=5.
// Inputs change 1 time unit after a rising edge; that cycle is cycle 0 of each scenario.
module tb_btn_debounce_4;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_mis;

  btn_debounce_4_if bus();

  btn_debounce_4 #(
    .DEBOUNCE_CNT(8),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Step n cycles, counting press/release pulses on one channel and where they fell.
  task automatic watch(input int n, input int ch, output int np, output int nr,
                       output int first_p, output int last_p, output int last_r);
    np = 0; nr = 0; first_p = -1; last_p = -1; last_r = -1;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (bus.btn_press[ch]) begin
        np++;
        if (first_p < 0) first_p = i;
        last_p = i;
      end
      if (bus.btn_release[ch]) begin
        nr++;
        last_r = i;
      end
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_level"},   int'(bus.btn_level),   0);
    check({pfx, "_press"},   int'(bus.btn_press),   0);
    check({pfx, "_release"}, int'(bus.btn_release), 0);
    check({pfx, "_sel_idx"}, int'(bus.sel_idx),     0);
    check({pfx, "_sel_vld"}, int'(bus.sel_valid),   0);
    check({pfx, "_any"},     int'(bus.any_pressed), 0);
  endtask

  initial begin
    int np, nr, fp, lp, lr, tp, tr;
    n_vec = 0;
    n_mis = 0;
    rst = 1'b1;
    bus.btn_in = 4'b0000;
    step(3);
    rst = 1'b0;
    check_all_zero("reset");

    // Clean press on channel 2
    bus.btn_in[2] = 1'b1;
    step(9);
    check("t1_press_c9", int'(bus.btn_press[2]), 0);
    step(1);
    check("t1_press_c10", int'(bus.btn_press[2]), 1);
    check("t1_level_c10", int'(bus.btn_level[2]), 1);
    check("t1_valid_c10", int'(bus.sel_valid), 0);
    check("t1_any_c10",   int'(bus.any_pressed), 0);
    step(1);
    check("t1_press_c11", int'(bus.btn_press[2]), 0);
    check("t1_sel_idx",   int'(bus.sel_idx), 2);
    check("t1_sel_valid", int'(bus.sel_valid), 1);
    check("t1_any_c11",   int'(bus.any_pressed), 1);

    // Release of channel 2
    bus.btn_in[2] = 1'b0;
    watch(12, 2, np, nr, fp, lp, lr);
    check("t3_releases",   nr, 1);
    check("t3_release_at", lr, 10);
    check("t3_presses",    np, 0);
    check("t3_level",      int'(bus.btn_level[2]), 0);
    check("t3_sel_idx",    int'(bus.sel_idx), 2);

    // Bounce on channel 0: 1,0,1,0 at 3-cycle intervals, then steady 1
    tp = 0; tr = 0;
    for (int k = 0; k < 4; k++) begin
      bus.btn_in[0] = (k % 2 == 0);
      watch(3, 0, np, nr, fp, lp, lr);
      tp += np;
      tr += nr;
    end
    check("t2_bounce_press", tp, 0);
    bus.btn_in[0] = 1'b1;
    watch(14, 0, np, nr, fp, lp, lr);
    check("t2_presses",  np, 1);
    check("t2_press_at", fp, 10);
    check("t2_releases", tr + nr, 0);
    check("t2_sel_idx",  int'(bus.sel_idx), 0);

    bus.btn_in[0] = 1'b0;
    step(14);

    // Simultaneous press on channels 3 and 1
    bus.btn_in[3] = 1'b1;
    bus.btn_in[1] = 1'b1;
    step(9);
    check("t4_press_c9", int'(bus.btn_press), 0);
    step(1);
    check("t4_press_c10", int'(bus.btn_press), 10);
    step(1);
    check("t4_sel_idx", int'(bus.sel_idx), 1);
    check("t4_any",     int'(bus.any_pressed), 1);

    bus.btn_in = 4'b0000;
    step(14);
    check("t4_level_off", int'(bus.btn_level), 0);

    // Reset in the middle of a debounce on channel 1
    bus.btn_in[1] = 1'b1;
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_all_zero("t5_post_rst");
    watch(12, 1, np, nr, fp, lp, lr);
    check("t5_presses",  np, 1);
    check("t5_press_at", fp, 10);
    check("t5_sel_idx",  int'(bus.sel_idx), 1);

    bus.btn_in = 4'b0000;
    step(14);

    // Hold channel 0 for 50 cycles after acceptance
    bus.btn_in[0] = 1'b1;
    step(10);
    check("t6_accept", int'(bus.btn_press[0]), 1);
    watch(50, 0, np, nr, fp, lp, lr);
`ifdef BTN_AUTOREPEAT_EN
    check("t6_repeats",     np, 7);
    check("t6_first_rpt",   fp, 20);
    check("t6_last_rpt",    lp, 50);
`else
    check("t6_repeats",     np, 0);
    check("t6_first_rpt",   fp, -1);
    check("t6_last_rpt",    lp, -1);
`endif
    check("t6_level", int'(bus.btn_level[0]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/btn_debounce_4.md
# btn_debounce_4

Four-channel push-button input conditioner: the input-side companion to the 4-LED sequencer on the board. It synchronises raw button pins, debounces each channel independently, and produces stable levels, single-cycle press/release events, and a latched "last pressed" index. Downstream LED and mode logic consume these outputs.

## Interface
- `DEBOUNCE_CNT`, default 250000: consecutive stable cycles required to accept a level change (5 ms at 50 MHz); legal range 2..2^24.
- `REPEAT_DELAY`, default 25000000: hold cycles from accepted press to first auto-repeat event (500 ms). Used only with `BTN_AUTOREPEAT_EN`.
- `REPEAT_RATE`, default 5000000: cycles between subsequent auto-repeat events (100 ms). Used only with `BTN_AUTOREPEAT_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `btn_in`  in  4  raw button pins, asynchronous, active-high (1 = pressed).
- `btn_level`  out  4  debounced level per channel.
- `btn_press`  out  4  one-cycle pulse per accepted press (and per repeat).
- `btn_release`  out  4  one-cycle pulse per accepted release.
- `sel_idx`  out  2  index of most recently pressed channel.
- `sel_valid`  out  1  high once any press has been accepted since reset.
- `any_pressed`  out  1  OR of `btn_level`.

## Operation
- Each channel has a 2-FF synchroniser (`s0`→`s1`) and uses `s1` only.
- Each channel runs an FSM:
  - RELEASED: `s1`=1 → PRESS_WAIT with counter cleared.
  - PRESS_WAIT: on `s1`=0 → RELEASED (bounce), counter cleared. Otherwise counter increments. Reaching `DEBOUNCE_CNT`-1 → PRESSED, with `btn_level`=1 and `btn_press`=1 for one cycle.
  - PRESSED: `s1`=0 → RELEASE_WAIT with counter cleared.
  - RELEASE_WAIT: mirror of PRESS_WAIT. On completion → RELEASED, with `btn_level`=0 and `btn_release`=1 for one cycle. On `s1`=1 → PRESSED with no event.
- Debounce counter width is `$clog2(DEBOUNCE_CNT)`. Counter saturates and never wraps.
- `sel_idx` loads on any `btn_press` bit. With simultaneous presses, the lowest index wins. `sel_valid` sets on the first load and clears only on reset.
- Channels are fully independent. Events on different channels may coincide in the same cycle.

## Timing
- Reset: all FSMs go to RELEASED; synchroniser FFs, counters, `btn_level`, `btn_press`, `btn_release`, `sel_idx`, `sel_valid` and `any_pressed` all go to 0.
- A button held through reset is detected as a fresh press after full latency.
- Latency: `btn_in` edge at cycle 0 reaches `s1` at cycle 2. The clean edge is accepted, and `btn_level`/`btn_press` assert, at cycle 2+`DEBOUNCE_CNT`.
- `sel_idx`/`sel_valid` update one cycle after the `btn_press` pulse.
- `any_pressed` is registered and follows `btn_level` by one cycle.
- Any bounce shorter than `DEBOUNCE_CNT` cycles restarts the count and produces no event.
- `rst` asserted mid-debounce or mid-repeat discards all progress next cycle. No events are emitted in the reset cycle.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: each channel has a repeat counter that clears on accepted press.
  - While the channel is in PRESSED, `btn_press` re-pulses after `REPEAT_DELAY` cycles, then every `REPEAT_RATE` cycles.
  - Each repeat also reloads `sel_idx`.
  - Leaving PRESSED (including entering RELEASE_WAIT) clears the repeat counter. Repeats resume timing from zero if the channel bounces back to PRESSED.
- `BTN_AUTOREPEAT_EN` undefined: exactly one `btn_press` per accepted press. No repeat counters are synthesised, and `REPEAT_*` are ignored.

## Test plan
Use `DEBOUNCE_CNT`=8, `REPEAT_DELAY`=20, `REPEAT_RATE`=5.
1. Clean press: `btn_in[2]` 0→1 at cycle 0, held. Required: `btn_press[2]` pulses at cycle 10; `btn_level[2]`=1 from cycle 10; `sel_idx`=2 and `sel_valid`=1 at cycle 11.
2. Bounce rejection: `btn_in[0]` toggles 1,0,1,0 at 3-cycle intervals, then stays 1. Required: one `btn_press[0]`, exactly 10 cycles after the final rising edge; no release events.
3. Release: after test 1, drop `btn_in[2]`. Required: `btn_release[2]` pulses 10 cycles later; `btn_level[2]`=0; `sel_idx` stays 2.
4. Simultaneous press on `btn_in[3]` and `btn_in[1]` in the same cycle. Required: both press bits pulse in the same cycle; `sel_idx`=1.
5. Reset mid-debounce: raise `btn_in[1]`, assert `rst` at cycle 5 for 1 cycle, keep the button held. Required: all outputs 0 after reset; press accepted 10 cycles after `rst` deasserts.
6. With `BTN_AUTOREPEAT_EN`, hold `btn_in[0]` for 50 cycles after acceptance. Required: `btn_press[0]` pulses at +0, +20, +25, +30 … +50. Without the macro: a single pulse only.
